// File: rtl/player_pkg.sv
// Shared types, default parameters and card helpers for the player engine.
package player_pkg;

  localparam int HAND_SIZE_DEF  = 5;
  localparam int CARD_W_DEF     = 6;
  localparam int CHIP_W_DEF     = 8;
  localparam int DATA_W_DEF     = 8;
  localparam int MAX_SWAP_DEF   = 4;
  localparam int INIT_CHIPS_DEF = 100;

  // Cards are zero-extended into this container so helpers work for any CARD_W.
  localparam int CARD_MAX_W = 16;
  typedef logic [CARD_MAX_W-1:0] card_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RECV      = 3'd1,
    ST_READY     = 3'd2,
    ST_SEND_SWAP = 3'd3,
    ST_RECV_SWAP = 3'd4,
    ST_SEND_BET  = 3'd5,
    ST_WAIT_POT  = 3'd6
  } state_e;

  function automatic logic [CARD_MAX_W-3:0] card_rank(card_t c);
    return c[CARD_MAX_W-1:2];
  endfunction

  function automatic logic [1:0] card_suit(card_t c);
    return c[1:0];
  endfunction

  // Ordering key is {rank, suit}.
  function automatic logic card_gt(card_t a, card_t b);
    return {card_rank(a), card_suit(a)} > {card_rank(b), card_suit(b)};
  endfunction

endpackage

// File: rtl/player_hand_engine_hand_inserter.sv
// Combinational hand update: drop removed slots, compact, then insert one card in order.
module hand_inserter
  import player_pkg::*;
#(
  parameter int HAND_SIZE = HAND_SIZE_DEF,
  parameter int CARD_W    = CARD_W_DEF
) (
  input  logic [HAND_SIZE-1:0][CARD_W-1:0] hand_i,
  input  logic [3:0]                       count_i,
  input  logic [CARD_W-1:0]                card_i,
  input  logic                             ins_i,
  input  logic [HAND_SIZE-1:0]             rm_i,
  output logic [HAND_SIZE-1:0][CARD_W-1:0] hand_o,
  output logic [3:0]                       count_o
);

  int p;    // compacted index of the next kept card
  int f;    // final slot of a kept card after the insertion gap
  int pos;  // slot the new card lands in

  // Each kept card moves to its compacted slot, shifted up by one when it sorts after the new card.
  always_comb begin
    hand_o = '0;
    p      = 0;
    f      = 0;
    pos    = 0;
    for (int i = 0; i < HAND_SIZE; i++) begin
      if (i < int'(count_i) && !rm_i[i]) begin
        f = p + ((ins_i && card_gt(card_t'(hand_i[i]), card_t'(card_i))) ? 1 : 0);
        for (int j = 0; j < HAND_SIZE; j++)
          if (j == f) hand_o[j] = hand_i[i];
        if (!card_gt(card_t'(hand_i[i]), card_t'(card_i))) pos = pos + 1;
        p = p + 1;
      end
    end
    if (ins_i)
      for (int j = 0; j < HAND_SIZE; j++)
        if (j == pos) hand_o[j] = card_i;
    count_o = 4'(p + (ins_i ? 1 : 0));
  end

endmodule

// File: rtl/player_hand_engine.sv
// Player datapath: sorted hand, swap/bet exchange over the dealer byte link, chip bank.
module player_hand_engine
  import player_pkg::*;
#(
  parameter int HAND_SIZE  = HAND_SIZE_DEF,
  parameter int CARD_W     = CARD_W_DEF,
  parameter int CHIP_W     = CHIP_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_SWAP   = MAX_SWAP_DEF,
  parameter int INIT_CHIPS = INIT_CHIPS_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ack_in,
  input  logic                        cash_or_card,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        deal_start,
  input  logic                        swap_go,
  input  logic [HAND_SIZE-1:0]        swap_mask,
  input  logic                        bet_req,
  input  logic [CHIP_W-1:0]           bet_amt,
  input  logic                        game_over,
  input  logic [2:0]                  player_id,
  input  logic [2:0]                  winner,
  output logic [DATA_W-1:0]           data_out,
  output logic                        ackout,
  output logic                        fold,
  output logic [HAND_SIZE*CARD_W-1:0] hand,
  output logic [3:0]                  hand_count,
  output logic [CHIP_W-1:0]           chips,
  output logic [2:0]                  state,
  output logic                        busy
);

  state_e                          state_q, state_d;
  logic [HAND_SIZE-1:0][CARD_W-1:0] hand_q, hand_d, ins_hand;
  logic [3:0]                      cnt_q, cnt_d, ins_cnt;
  logic [CHIP_W-1:0]               chips_q, chips_d, bet_q, bet_d;
  logic [DATA_W-1:0]               dout_q, dout_d;
  logic                            ack_q, ack_d, fold_q, fold_d, sent_q, sent_d;
  logic [HAND_SIZE-1:0]            disc_q, disc_d, pend_q, pend_d, pend_low, swap_sel;
  logic [CARD_W-1:0]               send_card;
  logic [CHIP_W:0]                 pot_sum;
  logic                            ins_en;
  int                              taken;

  // A card word is taken only while our previous ackout is low, so ackout never runs back to back.
  assign ins_en = (state_q == ST_RECV || state_q == ST_RECV_SWAP) && !game_over &&
                  ack_in && !cash_or_card && !ack_q && (cnt_q < 4'(HAND_SIZE));
  assign pend_low = pend_q & (~pend_q + HAND_SIZE'(1));
  assign pot_sum  = {1'b0, chips_q} + {1'b0, data_in[CHIP_W-1:0]};

  // disc_q is nonzero only during SEND_SWAP, so it doubles as the compaction mask.
  hand_inserter #(.HAND_SIZE(HAND_SIZE), .CARD_W(CARD_W)) u_ins (
    .hand_i (hand_q),
    .count_i(cnt_q),
    .card_i (data_in[CARD_W-1:0]),
    .ins_i  (ins_en),
    .rm_i   (disc_q),
    .hand_o (ins_hand),
    .count_o(ins_cnt)
  );

  // Keep the lowest-index discard bits, at most MAX_SWAP of them.
  always_comb begin
    swap_sel = '0;
    taken    = 0;
    for (int i = 0; i < HAND_SIZE; i++)
      if (swap_mask[i] && taken < MAX_SWAP) begin
        swap_sel[i] = 1'b1;
        taken       = taken + 1;
      end
  end

  // Card in the lowest pending discard slot.
  always_comb begin
    send_card = '0;
    for (int i = 0; i < HAND_SIZE; i++)
      if (pend_low[i]) send_card = send_card | hand_q[i];
  end

  // Next-state and datapath updates; game_over overrides everything.
  always_comb begin
    state_d = state_q;
    hand_d  = hand_q;
    cnt_d   = cnt_q;
    chips_d = chips_q;
    bet_d   = bet_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    fold_d  = fold_q;
    sent_d  = sent_q;
    disc_d  = disc_q;
    pend_d  = pend_q;
    if (game_over) begin
      sent_d = 1'b0;
      disc_d = '0;
      pend_d = '0;
      if (winner == player_id && !fold_q) begin
        state_d = ST_WAIT_POT;
      end else begin
        state_d = ST_IDLE;
        hand_d  = '0;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: if (deal_start) begin
          state_d = ST_RECV;
          hand_d  = '0;
          cnt_d   = '0;
          fold_d  = 1'b0;
        end
        ST_RECV, ST_RECV_SWAP: if (ins_en) begin
          hand_d = ins_hand;
          cnt_d  = ins_cnt;
          ack_d  = 1'b1;
          if (ins_cnt == 4'(HAND_SIZE)) state_d = ST_READY;
        end
        ST_READY: begin
          if (swap_go) begin
            if (|swap_mask) begin
              disc_d  = swap_sel;
              pend_d  = swap_sel;
              sent_d  = 1'b0;
              state_d = ST_SEND_SWAP;
            end
          end else if (bet_req && !fold_q) begin
            bet_d   = bet_amt;
            sent_d  = 1'b0;
            state_d = ST_SEND_BET;
          end
        end
        ST_SEND_SWAP: begin
          if (!sent_q) begin
            dout_d = DATA_W'(send_card);
            ack_d  = 1'b1;
            sent_d = 1'b1;
          end else if (ack_in) begin
            sent_d = 1'b0;
            pend_d = pend_q & ~pend_low;
            if ((pend_q & ~pend_low) == '0) begin
              hand_d  = ins_hand;
              cnt_d   = ins_cnt;
              disc_d  = '0;
              state_d = ST_RECV_SWAP;
            end
          end
        end
        ST_SEND_BET: begin
          if (!sent_q) begin
            if (bet_q > chips_q) begin
              fold_d  = 1'b1;
              state_d = ST_READY;
            end else begin
              dout_d = DATA_W'(bet_q);
              ack_d  = 1'b1;
              sent_d = 1'b1;
            end
          end else if (ack_in) begin
            chips_d = chips_q - bet_q;
            sent_d  = 1'b0;
            state_d = ST_READY;
          end
        end
        ST_WAIT_POT: if (ack_in && cash_or_card && !ack_q) begin
          chips_d = pot_sum[CHIP_W] ? '1 : pot_sum[CHIP_W-1:0];
          ack_d   = 1'b1;
          hand_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hand_q  <= '0;
      cnt_q   <= '0;
      chips_q <= CHIP_W'(INIT_CHIPS);
      bet_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      fold_q  <= 1'b0;
      sent_q  <= 1'b0;
      disc_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      hand_q  <= hand_d;
      cnt_q   <= cnt_d;
      chips_q <= chips_d;
      bet_q   <= bet_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      fold_q  <= fold_d;
      sent_q  <= sent_d;
      disc_q  <= disc_d;
      pend_q  <= pend_d;
    end
  end

  assign data_out   = dout_q;
  assign ackout     = ack_q;
  assign fold       = fold_q;
  assign hand       = hand_q;
  assign hand_count = cnt_q;
  assign chips      = chips_q;
  assign state      = state_q;
  assign busy       = !(state_q == ST_IDLE || state_q == ST_READY);

endmodule

// File: tb/tb_player_hand_engine.sv
// Directed bench for player_hand_engine: 5-card instance plus a 7-card instance.
module tb_player_hand_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ack_in = 1'b0, cash_or_card = 1'b0, deal_start = 1'b0;
  logic        swap_go = 1'b0, bet_req = 1'b0, game_over = 1'b0;
  logic [7:0]  data_in = '0, bet_amt = '0;
  logic [4:0]  swap_mask = '0;
  logic [2:0]  player_id = 3'd2, winner = 3'd0;
  logic [7:0]  data_out, chips;
  logic        ackout, fold, busy;
  logic [29:0] hand;
  logic [3:0]  hand_count;
  logic [2:0]  state;

  logic        ack7 = 1'b0, deal7 = 1'b0;
  logic [7:0]  data7 = '0;
  logic [7:0]  data_out7, chips7;
  logic        ackout7, fold7, busy7;
  logic [41:0] hand7;
  logic [3:0]  count7;
  logic [2:0]  state7;
  logic [6:0]  zero7 = '0;
  logic [7:0]  zero8 = '0;
  logic        zero1 = 1'b0;

  int tests = 0, fails = 0, ackn = 0, consec = 0;
  logic prev_ack = 1'b0;

  typedef struct {
    logic [5:0]  card;
    logic [29:0] hand;
    logic [3:0]  cnt;
    logic [2:0]  st;
  } vec_t;
  vec_t tbl [9];
  logic [5:0] cards7 [7];

  always #5 clock = ~clock;

  player_hand_engine dut (
    .clock(clock), .reset(reset), .ack_in(ack_in), .cash_or_card(cash_or_card),
    .data_in(data_in), .deal_start(deal_start), .swap_go(swap_go), .swap_mask(swap_mask),
    .bet_req(bet_req), .bet_amt(bet_amt), .game_over(game_over), .player_id(player_id),
    .winner(winner), .data_out(data_out), .ackout(ackout), .fold(fold), .hand(hand),
    .hand_count(hand_count), .chips(chips), .state(state), .busy(busy)
  );

  player_hand_engine #(.HAND_SIZE(7), .CARD_W(6), .DATA_W(8)) dut7 (
    .clock(clock), .reset(reset), .ack_in(ack7), .cash_or_card(zero1),
    .data_in(data7), .deal_start(deal7), .swap_go(zero1), .swap_mask(zero7),
    .bet_req(zero1), .bet_amt(zero8), .game_over(zero1), .player_id(player_id),
    .winner(winner), .data_out(data_out7), .ackout(ackout7), .fold(fold7), .hand(hand7),
    .hand_count(count7), .chips(chips7), .state(state7), .busy(busy7)
  );

  // Count ackout pulses and flag any back-to-back pair.
  always @(negedge clock) begin
    if (ackout && prev_ack) consec <= consec + 1;
    if (ackout) ackn <= ackn + 1;
    prev_ack <= ackout;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input string name);
    tick();
    for (int n = 0; n < 8 && !ackout; n++) tick();
    check(name, 64'(ackout), 64'd1);
  endtask

  task automatic apply(input int k);
    data_in = {2'b00, tbl[k].card}; cash_or_card = 1'b0; ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check($sformatf("hand_%0d", k), 64'(hand), 64'(tbl[k].hand));
    check($sformatf("cnt_%0d", k), 64'(hand_count), 64'(tbl[k].cnt));
    check($sformatf("state_%0d", k), 64'(state), 64'(tbl[k].st));
    check($sformatf("ack_%0d", k), 64'(ackout), 64'd1);
    tick();
    check($sformatf("ackoff_%0d", k), 64'(ackout), 64'd0);
  endtask

  task automatic deal();
    deal_start = 1'b1;
    tick();
    deal_start = 1'b0;
    check("deal_state", 64'(state), 64'd1);
    check("deal_fold", 64'(fold), 64'd0);
    for (int k = 0; k < 5; k++) apply(k);
  endtask

  task automatic bet_ok(input logic [7:0] amt, input logic [7:0] exp_chips);
    bet_amt = amt; bet_req = 1'b1;
    tick();
    bet_req = 1'b0;
    check("bet_state", 64'(state), 64'd5);
    wait_ack("bet_ack");
    check("bet_data", 64'(data_out), 64'(amt));
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check("bet_chips", 64'(chips), 64'(exp_chips));
    check("bet_ready", 64'(state), 64'd2);
  endtask

  initial begin
    int a0;
    tbl[0] = '{6'h2D, {6'h00, 6'h00, 6'h00, 6'h00, 6'h2D}, 4'd1, 3'd1};
    tbl[1] = '{6'h05, {6'h00, 6'h00, 6'h00, 6'h2D, 6'h05}, 4'd2, 3'd1};
    tbl[2] = '{6'h3C, {6'h00, 6'h00, 6'h3C, 6'h2D, 6'h05}, 4'd3, 3'd1};
    tbl[3] = '{6'h11, {6'h00, 6'h3C, 6'h2D, 6'h11, 6'h05}, 4'd4, 3'd1};
    tbl[4] = '{6'h05, {6'h3C, 6'h2D, 6'h11, 6'h05, 6'h05}, 4'd5, 3'd2};
    tbl[5] = '{6'h08, {6'h00, 6'h00, 6'h00, 6'h3C, 6'h08}, 4'd2, 3'd4};
    tbl[6] = '{6'h3F, {6'h00, 6'h00, 6'h3F, 6'h3C, 6'h08}, 4'd3, 3'd4};
    tbl[7] = '{6'h20, {6'h00, 6'h3F, 6'h3C, 6'h20, 6'h08}, 4'd4, 3'd4};
    tbl[8] = '{6'h01, {6'h3F, 6'h3C, 6'h20, 6'h08, 6'h01}, 4'd5, 3'd2};
    cards7 = '{6'h2D, 6'h05, 6'h3C, 6'h11, 6'h05, 6'h3F, 6'h00};

    // Reset values
    tick(); tick();
    check("rst_state", 64'(state), 64'd0);
    check("rst_chips", 64'(chips), 64'd100);
    check("rst_hand", 64'(hand), 64'd0);
    check("rst_cnt", 64'(hand_count), 64'd0);
    check("rst_ack", 64'(ackout), 64'd0);
    check("rst_dout", 64'(data_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Hand 1: deal, full-mask swap, bet, win the pot
    a0 = ackn;
    deal();
    check("deal_ackouts", 64'(ackn - a0), 64'd5);
    swap_mask = 5'b00000; swap_go = 1'b1;
    tick();
    swap_go = 1'b0;
    check("zero_mask", 64'(state), 64'd2);
    swap_mask = 5'b11111; swap_go = 1'b1; bet_req = 1'b1; bet_amt = 8'd10;
    tick();
    swap_go = 1'b0; bet_req = 1'b0;
    check("swap_state", 64'(state), 64'd3);
    check("swap_busy", 64'(busy), 64'd1);
    begin
      logic [5:0] exp_send [4];
      exp_send = '{6'h05, 6'h05, 6'h11, 6'h2D};
      for (int k = 0; k < 4; k++) begin
        wait_ack($sformatf("swap_ack_%0d", k));
        check($sformatf("swap_data_%0d", k), 64'(data_out), 64'(exp_send[k]));
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
      end
    end
    check("swap_cnt", 64'(hand_count), 64'd1);
    check("swap_hand", 64'(hand), 64'h3C);
    check("swap_rstate", 64'(state), 64'd4);
    check("swap_chips", 64'(chips), 64'd100);
    for (int k = 5; k < 9; k++) apply(k);
    bet_ok(8'd30, 8'd70);
    winner = 3'd2; game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("pot_wait", 64'(state), 64'd6);
    data_in = 8'd200; cash_or_card = 1'b1; ack_in = 1'b1;
    tick();
    ack_in = 1'b0; cash_or_card = 1'b0;
    check("pot_chips", 64'(chips), 64'd255);
    check("pot_ack", 64'(ackout), 64'd1);
    check("pot_idle", 64'(state), 64'd0);
    check("pot_cnt", 64'(hand_count), 64'd0);
    tick();

    // Hand 2: check, bet, overbet folds, folded winner gets nothing
    deal();
    bet_ok(8'd0, 8'd255);
    bet_ok(8'd200, 8'd55);
    a0 = ackn;
    bet_amt = 8'd80; bet_req = 1'b1;
    tick();
    bet_req = 1'b0;
    tick();
    check("fold_flag", 64'(fold), 64'd1);
    check("fold_chips", 64'(chips), 64'd55);
    check("fold_state", 64'(state), 64'd2);
    bet_amt = 8'd1; bet_req = 1'b1;
    tick();
    bet_req = 1'b0;
    check("fold_ignore", 64'(state), 64'd2);
    check("fold_noack", 64'(ackn - a0), 64'd0);
    winner = 3'd2; game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("foldwin_idle", 64'(state), 64'd0);
    check("foldwin_cnt", 64'(hand_count), 64'd0);
    check("foldwin_chips", 64'(chips), 64'd55);

    // Hand 3: game_over in the middle of a swap
    deal();
    swap_mask = 5'b00110; swap_go = 1'b1;
    tick();
    swap_go = 1'b0;
    wait_ack("abort_ack");
    check("abort_data", 64'(data_out), 64'h05);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    winner = 3'd3; game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("abort_state", 64'(state), 64'd0);
    check("abort_cnt", 64'(hand_count), 64'd0);
    check("abort_hand", 64'(hand), 64'd0);
    check("abort_chips", 64'(chips), 64'd55);
    check("abort_noack", 64'(ackout), 64'd0);

    // Async reset in the middle of RECV, no clock edge needed
    deal_start = 1'b1;
    tick();
    deal_start = 1'b0;
    apply(0); apply(1);
    #2 reset = 1'b1;
    #1;
    check("arst_state", 64'(state), 64'd0);
    check("arst_cnt", 64'(hand_count), 64'd0);
    check("arst_hand", 64'(hand), 64'd0);
    check("arst_chips", 64'(chips), 64'd100);
    check("arst_dout", 64'(data_out), 64'd0);
    check("arst_fold", 64'(fold), 64'd0);
    #1 reset = 1'b0;
    tick();

    // 7-card instance
    deal7 = 1'b1;
    tick();
    deal7 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      data7 = {2'b00, cards7[k]}; ack7 = 1'b1;
      tick();
      ack7 = 1'b0;
      if (k == 5) check("h7_recv", 64'(state7), 64'd1);
      if (k == 6) begin
        check("h7_ready", 64'(state7), 64'd2);
        check("h7_ack", 64'(ackout7), 64'd1);
      end
      tick();
    end
    check("h7_hand", 64'(hand7),
          64'({6'h3F, 6'h3C, 6'h2D, 6'h11, 6'h05, 6'h05, 6'h00}));
    check("h7_cnt", 64'(count7), 64'd7);
    check("h7_misc", 64'({chips7, data_out7, fold7, busy7}), 64'({8'd100, 8'd0, 1'b0, 1'b0}));

    check("ack_consec", 64'(consec), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
